// File: rtl/regfile_write_arbiter.sv
// Two-requester round-robin write arbiter in front of a single register-file write port.
// Writes to x0 are acknowledged without touching the register file; stalled writes time out.
module regfile_write_arbiter #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req0,
    input  logic        req1,
    input  logic [4:0]  reg0,
    input  logic [4:0]  reg1,
    input  logic [63:0] data0,
    input  logic [63:0] data1,
    output logic        done0,
    output logic        done1,
    output logic        rf_write_enable,
    output logic [4:0]  rf_write_register,
    output logic [63:0] rf_write_value,
    input  logic        rf_write_done,
    output logic        busy,
    output logic        grant_id,
    output logic        error
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ISSUE = 2'd1;
    localparam logic [1:0] WAIT  = 2'd2;
    localparam logic [1:0] ACK   = 2'd3;

    localparam logic [4:0] CNT_LAST = 5'(TIMEOUT - 1);

    logic [1:0]  state_q, state_d;
    logic        prio_q, prio_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [4:0]  hold_reg_q, hold_reg_d;
    logic [63:0] hold_data_q, hold_data_d;
    logic        grant_q, grant_d;
    logic        error_q, error_d;
    logic        sel;
    logic [4:0]  sel_reg;

    always_comb begin
        state_d     = state_q;
        prio_d      = prio_q;
        cnt_d       = cnt_q;
        hold_reg_d  = hold_reg_q;
        hold_data_d = hold_data_q;
        grant_d     = grant_q;
        error_d     = error_q;
        // Both requesting: priority holder wins; otherwise whoever is asking.
        sel         = (req0 && req1) ? prio_q : req1;
        sel_reg     = sel ? reg1 : reg0;
        case (state_q)
            IDLE: begin
                if (req0 || req1) begin
                    grant_d     = sel;
                    hold_reg_d  = sel_reg;
                    hold_data_d = sel ? data1 : data0;
                    state_d     = (sel_reg == 5'd0) ? ACK : ISSUE;
                end
            end
            ISSUE: begin
                cnt_d   = '0;
                state_d = WAIT;
            end
            WAIT: begin
                if (rf_write_done) begin
                    state_d = ACK;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = ACK;
                    error_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 5'd1;
                end
            end
            ACK: begin
                prio_d  = ~grant_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            prio_q      <= 1'b0;
            cnt_q       <= '0;
            hold_reg_q  <= '0;
            hold_data_q <= '0;
            grant_q     <= 1'b0;
            error_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            prio_q      <= prio_d;
            cnt_q       <= cnt_d;
            hold_reg_q  <= hold_reg_d;
            hold_data_q <= hold_data_d;
            grant_q     <= grant_d;
            error_q     <= error_d;
        end
    end

    // Outputs come straight from registered state so reset clears them asynchronously.
    assign busy              = (state_q != IDLE);
    assign rf_write_enable   = (state_q == ISSUE);
    assign rf_write_register = (state_q == ISSUE || state_q == WAIT) ? hold_reg_q  : '0;
    assign rf_write_value    = (state_q == ISSUE || state_q == WAIT) ? hold_data_q : '0;
    assign done0             = (state_q == ACK) && !grant_q;
    assign done1             = (state_q == ACK) && grant_q;
    assign grant_id          = grant_q;
    assign error             = error_q;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Randomised bench for regfile_write_arbiter: a transaction-level model predicts grant order,
// register-file traffic, completion timing and the sticky error flag.
module tb_regfile_write_arbiter;

    localparam int T = 16;

    logic        clk, reset;
    logic        req0, req1;
    logic [4:0]  reg0, reg1;
    logic [63:0] data0, data1;
    logic        done0, done1;
    logic        rf_write_enable;
    logic [4:0]  rf_write_register;
    logic [63:0] rf_write_value;
    logic        rf_write_done;
    logic        busy, grant_id, error;

    int checks = 0;
    int failures = 0;
    bit prio_m = 1'b0;
    bit err_exp = 1'b0;

    regfile_write_arbiter #(.TIMEOUT(T)) dut (
        .clk               (clk),
        .reset             (reset),
        .req0              (req0),
        .req1              (req1),
        .reg0              (reg0),
        .reg1              (reg1),
        .data0             (data0),
        .data1             (data1),
        .done0             (done0),
        .done1             (done1),
        .rf_write_enable   (rf_write_enable),
        .rf_write_register (rf_write_register),
        .rf_write_value    (rf_write_value),
        .rf_write_done     (rf_write_done),
        .busy              (busy),
        .grant_id          (grant_id),
        .error             (error)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic expect_outs(input string tag, input bit we, input logic [4:0] r,
                               input logic [63:0] v, input bit d0, input bit d1,
                               input bit bz, input bit err);
        check({tag, ".we"},    rf_write_enable,   we);
        check({tag, ".reg"},   rf_write_register, r);
        check({tag, ".val"},   rf_write_value,    v);
        check({tag, ".done0"}, done0,             d0);
        check({tag, ".done1"}, done1,             d1);
        check({tag, ".busy"},  busy,              bz);
        check({tag, ".error"}, error,             err);
    endtask

    // Serve one request from requester k; entered and left at a negedge in IDLE.
    // dly = WAIT cycle (1-based) in which rf_write_done is returned; > T means never.
    task automatic serve(input bit k, input logic [4:0] r, input logic [63:0] d, input int dly);
        int wend;
        expect_outs("idle", 0, 0, 0, 0, 0, 0, err_exp);
        @(posedge clk); #1;
        rf_write_done = 1'($urandom);
        @(negedge clk);
        check("grant", grant_id, k);
        if (r == 5'd0) begin
            expect_outs("x0ack", 0, 0, 0, !k, k, 1, err_exp);
        end else begin
            expect_outs("issue", 1, r, d, 0, 0, 1, err_exp);
            wend = (dly <= T) ? dly : T;
            for (int w = 1; w <= wend; w++) begin
                @(posedge clk); #1;
                rf_write_done = (w == dly);
                @(negedge clk);
                expect_outs("wait", 0, r, d, 0, 0, 1, err_exp);
            end
            if (dly > T) err_exp = 1'b1;
            @(posedge clk); #1;
            rf_write_done = 1'($urandom);
            @(negedge clk);
            check("ack.grant", grant_id, k);
            expect_outs("ack", 0, 0, 0, !k, k, 1, err_exp);
        end
        @(posedge clk); #1;
        if (k) req1 = 1'b0; else req0 = 1'b0;
        rf_write_done = 1'($urandom);
        prio_m = ~k;
        @(negedge clk);
    endtask

    function automatic int rand_dly();
        return ($urandom_range(0, 7) == 0) ? $urandom_range(T - 1, T + 3) : $urandom_range(1, 6);
    endfunction

    initial begin
        bit first;
        logic [1:0] pat;
        clk = 0; reset = 0; req0 = 0; req1 = 0; reg0 = 0; reg1 = 0;
        data0 = 0; data1 = 0; rf_write_done = 0;
        #3;
        expect_outs("reset", 0, 0, 0, 0, 0, 0, 0);
        check("reset.grant", grant_id, 0);
        @(negedge clk); #2 reset = 1;
        @(negedge clk);

        // Single write to r5, completion two cycles after the enable.
        req0 = 1; reg0 = 5; data0 = 64'h1234;
        serve(0, 5, 64'h1234, 2);

        // Reset restores priority to requester 0, then two rounds of contention.
        @(negedge clk); #2 reset = 0;
        @(negedge clk); #2 reset = 1; prio_m = 0;
        @(negedge clk);
        for (int n = 0; n < 2; n++) begin
            req0 = 1; req1 = 1; reg0 = 5'd3; reg1 = 5'd7;
            data0 = 64'hA0A0 + 64'(n); data1 = 64'hB0B0 + 64'(n);
            check("contend.prio", 32'(prio_m), 0);
            serve(0, reg0, data0, 1);
            serve(1, reg1, data1, 3);
        end

        // x0 drop from requester 1.
        req1 = 1; reg1 = 0; data1 = 64'hDEAD;
        serve(1, 0, 64'hDEAD, 1);

        // Completion on the last possible WAIT cycle beats the timeout.
        req0 = 1; reg0 = 5'd12; data0 = 64'hCAFE;
        serve(0, 12, 64'hCAFE, T);
        check("race.error", error, 0);

        // Reset in the middle of WAIT: no done pulse, priority back to requester 0.
        req1 = 1; reg1 = 5'd9; data1 = 64'h9999;
        check("mid.prio", 32'(prio_m), 1);
        @(posedge clk); #1;
        @(negedge clk);
        expect_outs("mid.issue", 1, 9, 64'h9999, 0, 0, 1, 0);
        @(posedge clk); #1;
        @(negedge clk);
        expect_outs("mid.wait", 0, 9, 64'h9999, 0, 0, 1, 0);
        #2 reset = 0;
        #1 expect_outs("mid.rst", 0, 0, 0, 0, 0, 0, 0);
        check("mid.rst.grant", grant_id, 0);
        @(negedge clk);
        expect_outs("mid.hold", 0, 0, 0, 0, 0, 0, 0);
        req1 = 0;
        #2 reset = 1; prio_m = 0; err_exp = 0;
        @(negedge clk);
        req0 = 1; req1 = 1; reg0 = 5'd1; reg1 = 5'd2; data0 = 64'h11; data1 = 64'h22;
        serve(0, 5'd1, 64'h11, 2);
        serve(1, 5'd2, 64'h22, 2);

        // Randomised traffic.
        for (int i = 0; i < 40; i++) begin
            pat = 2'($urandom_range(1, 3));
            req0 = pat[0]; req1 = pat[1];
            reg0 = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
            reg1 = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
            data0 = {$urandom, $urandom};
            data1 = {$urandom, $urandom};
            first = (pat == 2'b11) ? prio_m : pat[1];
            serve(first, first ? reg1 : reg0, first ? data1 : data0, rand_dly());
            if (pat == 2'b11)
                serve(~first, first ? reg0 : reg1, first ? data0 : data1, rand_dly());
        end

        // Guaranteed timeout, then error must remain set.
        req1 = 1; reg1 = 5'd30; data1 = 64'h5A5A;
        serve(1, 5'd30, 64'h5A5A, T + 2);
        check("timeout.error", error, 1);
        req0 = 1; reg0 = 5'd4; data0 = 64'h44;
        serve(0, 5'd4, 64'h44, 1);
        check("sticky.error", error, 1);
        #2 reset = 0;
        #1 check("final.rst.error", error, 0);
        #2 reset = 1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
